bin_to_bcd_seq: RTL and testbench

- Sequential binary-to-BCD converter for the FLOAT_TO_DECIMAL path, using shift-and-add-3 (double dabble).
- Takes the unsigned integer part produced by the float-unpacking stage and emits packed BCD digits.
- Its outputs feed the per-digit BCD correction/adder stage downstream.
- Processes one bit per clock under a start/busy/done handshake.

---
 rtl/bin_to_bcd_seq.sv | 124 ++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock.
// Outputs are registered and only update on the cycle done is asserted.
module bin_to_bcd_seq #(
   parameter int unsigned BIN_W  = 24,
   parameter int unsigned DIGITS = 8,
   parameter int unsigned CNT_W  = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [BIN_W-1:0]      bin_in,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic                  overflow
);

   localparam int unsigned BCD_W = 4 * DIGITS;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [BIN_W-1:0]   shift_q, shift_d;
   logic [BCD_W-1:0]   work_q, work_d;
   logic [BCD_W-1:0]   corr_c;
   logic [BCD_W-1:0]   bcd_q, bcd_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               ovf_q, ovf_d;
   logic               ovf_out_q, ovf_out_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               load_c;

   // Add-3 correction on each digit independently; no carry between digits.
   always_comb begin
      corr_c = work_q;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (work_q[4*i +: 4] >= 4'd5) begin
            corr_c[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
         end
      end
   end

   assign load_c = start && (state_q != SHIFT);

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      work_d    = work_q;
      cnt_d     = cnt_q;
      ovf_d     = ovf_q;
      bcd_d     = bcd_q;
      ovf_out_d = ovf_out_q;

      case (state_q)
         IDLE: begin
            state_d = IDLE;
         end
         SHIFT: begin
            work_d  = {corr_c[BCD_W-2:0], shift_q[BIN_W-1]};
            shift_d = shift_q << 1;
            ovf_d   = ovf_q | corr_c[BCD_W-1];
            cnt_d   = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d   = DONE;
               bcd_d     = work_d;
               ovf_out_d = ovf_d;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // A new operand is accepted from IDLE or, back-to-back, from DONE.
      if (load_c) begin
         state_d = SHIFT;
         shift_d = bin_in;
         work_d  = '0;
         ovf_d   = 1'b0;
         cnt_d   = CNT_W'(BIN_W);
      end

      busy_d = (state_d == SHIFT);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         work_q    <= '0;
         cnt_q     <= '0;
         ovf_q     <= 1'b0;
         bcd_q     <= '0;
         ovf_out_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         work_q    <= work_d;
         cnt_q     <= cnt_d;
         ovf_q     <= ovf_d;
         bcd_q     <= bcd_d;
         ovf_out_q <= ovf_out_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign bcd_out  = bcd_q;
   assign overflow = ovf_out_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: cycle-level behavioural model plus
// directed and randomized conversions on the default and a narrow instance.
module tb_bin_to_bcd_seq;

   localparam int unsigned BIN_W  = 24;
   localparam int unsigned DIGITS = 8;
   localparam int unsigned CNT_W  = 5;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [23:0] bin_in;
   logic        busy, done, overflow;
   logic [31:0] bcd_out;

   logic        start8;
   logic [7:0]  bin8;
   logic        busy8, done8, ovf8;
   logic [7:0]  bcd8;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS), .CNT_W(CNT_W)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
      .busy(busy), .done(done), .bcd_out(bcd_out), .overflow(overflow)
   );

   bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2), .CNT_W(4)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .bin_in(bin8),
      .busy(busy8), .done(done8), .bcd_out(bcd8), .overflow(ovf8)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: decimal digits of v modulo 10^digs, plus the does-not-fit flag.
   function automatic logic [63:0] ref_bcd(input longint unsigned v, input int digs);
      logic [63:0] r;
      r = '0;
      for (int i = 0; i < digs; i++) begin
         r[4*i +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   function automatic logic ref_ovf(input longint unsigned v, input int digs);
      longint unsigned p;
      p = 1;
      for (int i = 0; i < digs; i++) p = p * 10;
      return v >= p;
   endfunction

   // Cycle model: a conversion occupies BIN_W busy cycles, then one done cycle.
   logic        m_busy, m_done, m_ovf;
   logic [31:0] m_bcd;
   logic [23:0] m_val;
   int          m_rem;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy <= 1'b0;
         m_done <= 1'b0;
         m_ovf  <= 1'b0;
         m_bcd  <= '0;
         m_val  <= '0;
         m_rem  <= 0;
      end else begin
         m_done <= 1'b0;
         if (m_busy) begin
            m_rem <= m_rem - 1;
            if (m_rem == 1) begin
               m_busy <= 1'b0;
               m_done <= 1'b1;
               m_bcd  <= 32'(ref_bcd(64'(m_val), int'(DIGITS)));
               m_ovf  <= ref_ovf(64'(m_val), int'(DIGITS));
            end
         end else if (start) begin
            m_val  <= bin_in;
            m_rem  <= int'(BIN_W);
            m_busy <= 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      logic bad_digit;
      check("busy", 64'(busy), 64'(m_busy));
      check("done", 64'(done), 64'(m_done));
      check("bcd_out", 64'(bcd_out), 64'(m_bcd));
      check("overflow", 64'(overflow), 64'(m_ovf));
      if (busy) begin
         bad_digit = 1'b0;
         for (int d = 0; d < int'(DIGITS); d++) begin
            if (u_dut.work_q[4*d +: 4] > 4'd9) bad_digit = 1'b1;
         end
         check("digit_range", 64'(bad_digit), 64'd0);
      end
   end

   task automatic pulse_start(input logic [23:0] v);
      @(posedge clk); #1;
      start  = 1'b1;
      bin_in = v;
      @(posedge clk); #1;
      start  = 1'b0;
   endtask

   task automatic wait_done(output int lat);
      lat = -1;
      for (int c = 1; c <= 60; c++) begin
         @(negedge clk);
         if (done) begin
            lat = c;
            break;
         end
      end
   endtask

   task automatic conv(input logic [23:0] v, input logic [31:0] exp_bcd,
                       input logic exp_ovf, input string name);
      int lat;
      pulse_start(v);
      wait_done(lat);
      check({name, "_latency"}, 64'(lat), 64'(BIN_W + 1));
      check({name, "_bcd"}, 64'(bcd_out), 64'(exp_bcd));
      check({name, "_ovf"}, 64'(overflow), 64'(exp_ovf));
   endtask

   task automatic conv8(input logic [7:0] v, input logic [7:0] exp_bcd,
                        input logic exp_ovf, input string name);
      int lat;
      @(posedge clk); #1;
      start8 = 1'b1;
      bin8   = v;
      @(posedge clk); #1;
      start8 = 1'b0;
      lat = -1;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         if (done8) begin
            lat = c;
            break;
         end
      end
      check({name, "_latency"}, 64'(lat), 64'd9);
      check({name, "_bcd"}, 64'(bcd8), 64'(exp_bcd));
      check({name, "_ovf"}, 64'(ovf8), 64'(exp_ovf));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, dones;
      logic [23:0] v;

      rst_n = 1'b0; start = 1'b0; bin_in = '0; start8 = 1'b0; bin8 = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_done", 64'(done), 64'd0);
      check("reset_bcd", 64'(bcd_out), 64'd0);
      check("reset_ovf", 64'(overflow), 64'd0);
      rst_n = 1'b1;

      check("model_255", ref_bcd(255, 8), 64'h255);
      check("model_ffffff", ref_bcd(24'hFFFFFF, 8), 64'h16777215);
      check("model_255_d2", ref_bcd(255, 2), 64'h55);
      check("model_ovf_d2", 64'(ref_ovf(255, 2)), 64'd1);

      conv(24'd0, 32'h0000_0000, 1'b0, "zero");
      conv(24'd255, 32'h0000_0255, 1'b0, "d255");
      conv(24'hFFFFFF, 32'h1677_7215, 1'b0, "max");

      // Start pulse during a running conversion must be ignored.
      pulse_start(24'd1234);
      dones = 0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (done) dones++;
         if (c == 4) begin start = 1'b1; bin_in = 24'd7; end
         if (c == 5) start = 1'b0;
         if (c == 25) check("ignore_bcd", 64'(bcd_out), 64'h1234);
      end
      check("ignore_done_count", 64'(dones), 64'd1);

      // Start held high: back-to-back conversions every BIN_W+1 cycles.
      @(posedge clk); #1;
      start  = 1'b1;
      bin_in = 24'd10;
      for (int k = 0; k < 6; k++) begin
         wait_done(lat);
         check("b2b_gap", 64'(lat), (k == 0) ? 64'd26 : 64'd25);
         check("b2b_bcd", 64'(bcd_out), (k % 2 == 0) ? 64'h10 : 64'h999999);
         bin_in = (k % 2 == 0) ? 24'd999999 : 24'd10;
         if (k == 5) start = 1'b0;
      end

      // Reset in the middle of a conversion aborts without a done pulse.
      pulse_start(24'd1234);
      repeat (11) @(negedge clk);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_bcd", 64'(bcd_out), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      dones = 0;
      repeat (30) begin
         @(negedge clk);
         if (done) dones++;
      end
      check("abort_no_done", 64'(dones), 64'd0);
      conv(24'd42, 32'h0000_0042, 1'b0, "after_abort");

      for (int i = 0; i < 40; i++) begin
         v = (i % 4 == 0) ? 24'($urandom_range(0, 99)) : 24'($urandom_range(0, 24'hFFFFFF));
         conv(v, 32'(ref_bcd(64'(v), 8)), 1'b0, "rand");
      end

      conv8(8'd255, 8'h55, 1'b1, "w8_255");
      conv8(8'd99, 8'h99, 1'b0, "w8_99");
      conv8(8'd100, 8'h00, 1'b1, "w8_100");
      for (int i = 0; i < 10; i++) begin
         logic [7:0] v8;
         v8 = 8'($urandom_range(0, 255));
         conv8(v8, 8'(ref_bcd(64'(v8), 2)), ref_ovf(64'(v8), 2), "w8_rand");
      end

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
